// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipelined processor: default widths,
// reset/NOP encodings and the fetch-stage state enumeration.
package pipe_pkg;

    localparam int          PIPE_PC_W      = 16;
    localparam int          PIPE_INSTR_W   = 16;
    localparam int          PIPE_RESET_PC  = 0;
    localparam logic [15:0] PIPE_NOP_INSTR = 16'h0000;

    // FETCH_NORMAL: requests flow freely.
    // FETCH_BUFFERED: skid holds an instruction, no new request.
    // FETCH_DROP: an in-flight response must be discarded, target parked.
    typedef enum logic [1:0] {
        FETCH_NORMAL   = 2'd0,
        FETCH_BUFFERED = 2'd1,
        FETCH_DROP     = 2'd2
    } fetchState_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction and its fetch address + 1
// while decode is stalled.
module fetch_skid
    import pipe_pkg::*;
#(
    parameter int PC_W    = PIPE_PC_W,
    parameter int INSTR_W = PIPE_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instrIn,
    input  logic [PC_W-1:0]    pc1In,
    output logic               full,
    output logic [INSTR_W-1:0] instrOut,
    output logic [PC_W-1:0]    pc1Out
);

    // Clear (flush) beats load, load beats unload; data is only captured on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            instrOut <= '0;
            pc1Out   <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full     <= 1'b1;
            instrOut <= instrIn;
            pc1Out   <= pc1In;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem req/ready handshake,
// absorbs stalled returns in a skid buffer, discards responses made stale by
// a redirect, and loads the IF/ID register for decode.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int                 PC_W      = PIPE_PC_W,
    parameter int                 INSTR_W   = PIPE_INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(PIPE_RESET_PC),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               RedirectE,
    input  logic [PC_W-1:0]    TargetE,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCPlus1D,
    output logic               ValidD
);

    fetchState_t        state;
    fetchState_t        stateNext;
    logic [PC_W-1:0]    addrQ;
    logic [PC_W-1:0]    addrNext;
    logic [PC_W-1:0]    addrPlus1;
    logic [PC_W-1:0]    tgtQ;
    logic [PC_W-1:0]    tgtNext;
    logic               pendQ;
    logic               accept;

    logic               skidLoad;
    logic               skidUnload;
    logic               skidClear;
    logic               skidFull;
    logic [INSTR_W-1:0] skidInstr;
    logic [PC_W-1:0]    skidPc1;

    logic               idBubble;
    logic               idFromFetch;
    logic               idFromSkid;
    logic [INSTR_W-1:0] instrDNext;
    logic [PC_W-1:0]    pc1DNext;
    logic               validDNext;

    assign imem_addr = addrQ;
    assign addrPlus1 = addrQ + PC_W'(1);
    assign accept    = imem_req & imem_ready;

    // State register plus fetch address, parked redirect target and the
    // "request raised but not yet accepted" flag that pins req/addr stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_NORMAL;
            addrQ <= RESET_PC;
            tgtQ  <= RESET_PC;
            pendQ <= 1'b0;
        end else begin
            state <= stateNext;
            addrQ <= addrNext;
            tgtQ  <= tgtNext;
            pendQ <= imem_req & ~imem_ready;
        end
    end

    // Next state and next fetch address; a redirect outranks decode stalls.
    always_comb begin
        stateNext = state;
        addrNext  = addrQ;
        tgtNext   = tgtQ;
        unique case (state)
            FETCH_NORMAL: begin
                if (RedirectE) begin
                    if (accept || !imem_req) begin
                        addrNext = TargetE;
                    end else begin
                        tgtNext   = TargetE;
                        stateNext = FETCH_DROP;
                    end
                end else if (accept) begin
                    addrNext = addrPlus1;
                    if (StallD) begin
                        stateNext = FETCH_BUFFERED;
                    end
                end
            end
            FETCH_BUFFERED: begin
                if (RedirectE) begin
                    addrNext  = TargetE;
                    stateNext = FETCH_NORMAL;
                end else if (!StallD) begin
                    stateNext = FETCH_NORMAL;
                end
            end
            FETCH_DROP: begin
                if (accept) begin
                    addrNext  = RedirectE ? TargetE : tgtQ;
                    stateNext = FETCH_NORMAL;
                end else if (RedirectE) begin
                    tgtNext = TargetE;
                end
            end
            default: begin
                stateNext = FETCH_NORMAL;
            end
        endcase
    end

    // Handshake request and the skid / IF/ID steering decoded from state.
    always_comb begin
        imem_req    = pendQ | ((state == FETCH_NORMAL) & ~StallF);
        skidLoad    = (state == FETCH_NORMAL) & accept & ~RedirectE & StallD;
        skidUnload  = (state == FETCH_BUFFERED) & skidFull & ~RedirectE & ~StallD;
        skidClear   = (state == FETCH_BUFFERED) & RedirectE;
        idFromFetch = (state == FETCH_NORMAL) & accept & ~RedirectE & ~StallD;
        idFromSkid  = skidUnload;
        idBubble    = RedirectE | (~StallD & ~idFromFetch & ~idFromSkid);
    end

    // Select what the IF/ID register takes this cycle; holding is the default.
    always_comb begin
        instrDNext = InstrD;
        pc1DNext   = PCPlus1D;
        validDNext = ValidD;
        if (idBubble) begin
            instrDNext = NOP_INSTR;
            pc1DNext   = '0;
            validDNext = 1'b0;
        end else if (idFromFetch) begin
            instrDNext = imem_rdata;
            pc1DNext   = addrPlus1;
            validDNext = 1'b1;
        end else if (idFromSkid) begin
            instrDNext = skidInstr;
            pc1DNext   = skidPc1;
            validDNext = 1'b1;
        end
    end

    // IF/ID pipeline register feeding decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCPlus1D <= '0;
            ValidD   <= 1'b0;
        end else begin
            InstrD   <= instrDNext;
            PCPlus1D <= pc1DNext;
            ValidD   <= validDNext;
        end
    end

    fetch_skid #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) uSkid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skidLoad),
        .unload   (skidUnload),
        .clear    (skidClear),
        .instrIn  (imem_rdata),
        .pc1In    (addrPlus1),
        .full     (skidFull),
        .instrOut (skidInstr),
        .pc1Out   (skidPc1)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch rules.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        StallD;
    logic        RedirectE;
    logic [15:0] TargetE;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] InstrD;
    logic [15:0] PCPlus1D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc1;
    } skidEnt_t;

    // Reference model state: what the fetch stage should be doing, in terms of
    // outstanding work rather than the design's encoding.
    logic [15:0] mAddr;
    logic        mOutstanding;
    logic        mDropping;
    logic [15:0] mDropTarget;
    skidEnt_t    mSkid[$];
    logic [15:0] mInstrD;
    logic [15:0] mPc1D;
    logic        mValidD;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .RedirectE  (RedirectE),
        .TargetE    (TargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCPlus1D   (PCPlus1D),
        .ValidD     (ValidD)
    );

    // Instruction memory contents are a fixed scramble of the address.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mAddr        = 16'h0000;
        mOutstanding = 1'b0;
        mDropping    = 1'b0;
        mDropTarget  = 16'h0000;
        mSkid.delete();
        mInstrD      = 16'h0000;
        mPc1D        = 16'h0000;
        mValidD      = 1'b0;
    endtask

    task automatic checkIfId(input string tag);
        checkOutput({tag, ".ValidD"}, 32'(ValidD), 32'(mValidD));
        checkOutput({tag, ".InstrD"}, 32'(InstrD), 32'(mInstrD));
        checkOutput({tag, ".PCPlus1D"}, 32'(PCPlus1D), 32'(mPc1D));
    endtask

    // One clock cycle: drive inputs away from the edge, check the request side,
    // advance the model, then check IF/ID after the edge.
    task automatic applyStimulus(input logic sF, input logic sD, input logic rd,
                                 input logic [15:0] tgt, input logic rdy, input string tag);
        logic expReq;
        logic acc;
        StallF     = sF;
        StallD     = sD;
        RedirectE  = rd;
        TargetE    = tgt;
        imem_ready = rdy;
        #1;
        expReq = mOutstanding | (~mDropping & (mSkid.size() == 0) & ~sF);
        checkOutput({tag, ".imem_req"}, 32'(imem_req), 32'(expReq));
        if (expReq) begin
            checkOutput({tag, ".imem_addr"}, 32'(imem_addr), 32'(mAddr));
        end
        acc = expReq & rdy;

        if (rd) begin
            mInstrD = 16'h0000;
            mPc1D   = 16'h0000;
            mValidD = 1'b0;
            if (mSkid.size() != 0) begin
                mSkid.delete();
                mAddr = tgt;
            end else if (mDropping) begin
                if (acc) begin
                    mAddr     = tgt;
                    mDropping = 1'b0;
                end else begin
                    mDropTarget = tgt;
                end
            end else if (acc || !expReq) begin
                mAddr = tgt;
            end else begin
                mDropping   = 1'b1;
                mDropTarget = tgt;
            end
        end else if (mDropping) begin
            if (acc) begin
                mAddr     = mDropTarget;
                mDropping = 1'b0;
            end
            if (!sD) begin
                mInstrD = 16'h0000;
                mPc1D   = 16'h0000;
                mValidD = 1'b0;
            end
        end else if (mSkid.size() != 0) begin
            if (!sD) begin
                mInstrD = mSkid[0].instr;
                mPc1D   = mSkid[0].pc1;
                mValidD = 1'b1;
                mSkid.delete();
            end
        end else if (acc) begin
            if (sD) begin
                mSkid.push_back({memWord(mAddr), 16'(mAddr + 16'd1)});
            end else begin
                mInstrD = memWord(mAddr);
                mPc1D   = 16'(mAddr + 16'd1);
                mValidD = 1'b1;
            end
            mAddr = 16'(mAddr + 16'd1);
        end else if (!sD) begin
            mInstrD = 16'h0000;
            mPc1D   = 16'h0000;
            mValidD = 1'b0;
        end
        mOutstanding = expReq & ~rdy;

        @(posedge clk);
        @(negedge clk);
        checkIfId(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        RedirectE  = 1'b0;
        TargetE    = 16'h0000;
        imem_ready = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkIfId("reset");
        checkOutput("reset.imem_addr", 32'(imem_addr), 32'h0000);
        rst_n = 1'b1;

        // Zero-wait streaming from address 0.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "stream");
        end
        checkOutput("stream.pc1", 32'(PCPlus1D), 32'h0005);
        checkOutput("stream.addr", 32'(imem_addr), 32'h0005);

        // Decode stall while address 5 returns: skid fills, requests stop.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, "stallD5");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, "stallD5b");
        checkOutput("buffered.req", 32'(imem_req), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, "stallD5c");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "release");
        checkOutput("release.instr", 32'(InstrD), 32'(memWord(16'h0005)));
        checkOutput("release.pc1", 32'(PCPlus1D), 32'h0006);
        checkOutput("release.addr", 32'(imem_addr), 32'h0006);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "fetch6");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "fetch7");

        // Wait states at 8 with a redirect in the first wait cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, "wait8a");
        checkOutput("wait8.addr", 32'(imem_addr), 32'h0008);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "wait8b");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "drop8");
        checkOutput("drop8.valid", 32'(ValidD), 32'h0);
        checkOutput("drop8.addr", 32'(imem_addr), 32'h0020);

        // Flush while the skid is full and decode is stalled.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, "skidfill");
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, "flushskid");
        checkOutput("flush.valid", 32'(ValidD), 32'h0);
        checkOutput("flush.instr", 32'(InstrD), 32'h0000);
        checkOutput("flush.addr", 32'(imem_addr), 32'h0040);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "fetch40");

        // Top of the address space wraps to zero.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, "toFFFF");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "fetchFFFF");
        checkOutput("wrap.pc1", 32'(PCPlus1D), 32'h0000);
        checkOutput("wrap.valid", 32'(ValidD), 32'h1);
        checkOutput("wrap.addr", 32'(imem_addr), 32'h0000);

        // Reset asserted while waiting at 0x12.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0012, 1'b1, "to12");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "wait12");
        checkOutput("wait12.addr", 32'(imem_addr), 32'h0012);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkIfId("midreset");
        checkOutput("midreset.addr", 32'(imem_addr), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "afterreset");
        checkOutput("afterreset.pc1", 32'(PCPlus1D), 32'h0001);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                               : 16'($urandom);
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 9) < 7, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 16-bit pipelined processor: owns the PC, drives the instruction-memory request/ready handshake, and loads the IF/ID pipeline register consumed by decode. It obeys the StallF/StallD outputs of the hazard unit and takes branch/jump redirects resolved in execute. A one-entry skid buffer absorbs an instruction that returns while decode is stalled. Responses already in flight when a redirect arrives are discarded.

## Interface
- PC_W, 16, PC / instruction-address width (word addressed)
- INSTR_W, 16, instruction width
- RESET_PC, 0, first fetch address after reset
- NOP_INSTR, 0, encoding loaded into InstrD on bubble/flush

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- StallF  in  1  from hazard unit; no new fetch request may start while high
- StallD  in  1  from hazard unit; IF/ID holds while high (unless redirect)
- RedirectE  in  1  taken branch/jump resolved in execute
- TargetE  in  PC_W  redirect target, valid with RedirectE
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address
- imem_ready  in  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  in  INSTR_W  instruction, valid when imem_req & imem_ready
- InstrD  out  INSTR_W  IF/ID instruction
- PCPlus1D  out  PC_W  IF/ID fetch address + 1
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- accept = imem_req & imem_ready. Registers: addr_q (next/in-flight address), pend_q (request outstanding), tgt_q, skid {instr, pc1}, state.
- States: FETCH (normal), BUFFERED (skid full, no request), DROP (in-flight response to be discarded, tgt_q holds new address).
- imem_addr = addr_q. imem_req = pend_q | (state==FETCH & ~StallF). Once imem_req rises without ready it stays high with imem_addr stable until accept, regardless of StallF/RedirectE.
- Priority: rst_n > RedirectE > StallD > normal.
- FETCH: accept & ~RedirectE -> addr_q <= addr_q+1; if StallD, instruction and addr+1 go to skid, -> BUFFERED; else go directly to IF/ID.
- FETCH, RedirectE: if accept this cycle -> data dropped, addr_q <= TargetE, stay FETCH. If request pending without accept -> tgt_q <= TargetE, -> DROP. If no request -> addr_q <= TargetE.
- BUFFERED: ~StallD -> skid to IF/ID, -> FETCH. RedirectE -> skid cleared, addr_q <= TargetE, -> FETCH.
- DROP: request held at old address; accept -> data discarded, addr_q <= tgt_q, -> FETCH. RedirectE in DROP overwrites tgt_q (latest wins).
- IF/ID: RedirectE -> bubble (InstrD=NOP_INSTR, ValidD=0, PCPlus1D=0) even if StallD. Else StallD -> hold. Else load skid (BUFFERED), accepted data (FETCH), or bubble.
- Address arithmetic modulo 2^PC_W; 0xFFFF+1 wraps to 0x0000 in addr_q and PCPlus1D.

## Timing
- Reset (async assert, sync-to-clk deassert assumed upstream): addr_q=RESET_PC, pend_q=0, state=FETCH, skid empty, InstrD=NOP_INSTR, PCPlus1D=0, ValidD=0; imem_req=1 in first cycle after deassert if StallF=0.
- Zero-wait memory (ready=1): one instruction per cycle; IF/ID valid the edge after accept (1-cycle latency).
- Redirect: imem_addr=TargetE the cycle after RedirectE (FETCH/BUFFERED), or the cycle after the dropped response (DROP).
- Redirect and StallD same cycle: flush wins. Redirect and accept same cycle: response never reaches IF/ID or skid.
- Reset mid-transaction: outstanding request abandoned; memory must tolerate a withdrawn req.

## Structure
- Shared package pipe_pkg: fetch state enum, NOP_INSTR, PC_W/INSTR_W defaults.
- One sub-module: fetch_skid (1-entry buffer: load, unload, clear, full flag, {instr, pc1} storage).

## Test plan
- ready=1, no stalls, reset PC 0 -> imem_addr 0,1,2,3; ValidD=1 with PCPlus1D 1,2,3 one cycle behind.
- StallD high 3 cycles while instr at addr 5 accepted -> state BUFFERED, imem_req=0; after release InstrD=mem[5], PCPlus1D=6, next request addr 6.
- ready low 2 cycles at addr 8, RedirectE to 0x20 in first wait cycle -> imem_addr stays 8 until ready, mem[8] never valid in ID, next request 0x20.
- RedirectE to 0x40 with StallD=1 and skid full -> ValidD=0, InstrD=NOP, next imem_addr 0x40.
- PC 0xFFFF fetched -> PCPlus1D=0x0000, next imem_addr 0x0000.
- rst_n asserted mid-wait at addr 0x12 -> outputs immediately at reset values, first request after release at RESET_PC.
